// File: rtl/vu_sample_ctrl.sv
// VU-meter level sequencer: sample tick, ADC start/done handshake, peak-hold (VU_PEAK_HOLD_EN), timeout error.
// Latency: tick edge -> adc_start next cycle; adc_done edge -> reg_load/reg_data next cycle.
// No backpressure: ticks arriving while busy or in error are dropped; the tick counter keeps running.
module vu_sample_ctrl #(
  parameter int DW                 = 8,
  parameter int SAMPLE_DIV         = 1000,
  parameter int TIMEOUT            = 255,
  parameter int HOLD_SAMPLES       = 16,
  parameter logic [DW-1:0] ERR_CODE = 8'hFF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          adc_done,
  input  logic [DW-1:0] adc_data,
  input  logic          error_clr,
  output logic          adc_start,
  output logic          reg_enable,
  output logic          reg_load,
  output logic [DW-1:0] reg_data,
  output logic          error,
  output logic          busy
);

  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int OW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  logic [2:0]    state;
  logic [TW-1:0] tick_cnt;
  logic [OW-1:0] to_cnt;
  logic          tick;
  logic [DW-1:0] level;

  assign tick       = enable && (tick_cnt == TW'(SAMPLE_DIV - 1));
  assign reg_enable = enable;
  assign adc_start  = (state == S_START);
  assign busy       = (state == S_START) || (state == S_WAIT) || (state == S_UPDATE);

  // Free-running sample divider; enable=0 freezes it rather than clearing it.
  always_ff @(posedge clock) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (enable) begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end
  end

`ifdef VU_PEAK_HOLD_EN
  localparam int HW = $clog2(HOLD_SAMPLES + 1);

  logic [DW-1:0] peak;
  logic [HW-1:0] hold_cnt;
  logic          take;

  // A new sample replaces the peak if it is at least as loud or the hold has expired.
  assign take  = (adc_data >= peak) || (hold_cnt == '0);
  assign level = take ? adc_data : peak;

  always_ff @(posedge clock) begin
    if (reset) begin
      peak     <= '0;
      hold_cnt <= '0;
    end else if (state == S_WAIT && adc_done) begin
      peak     <= level;
      hold_cnt <= take ? HW'(HOLD_SAMPLES - 1) : hold_cnt - 1'b1;
    end else if (state == S_ERROR && error_clr) begin
      peak     <= '0;
      hold_cnt <= '0;
    end
  end
`else
  logic hold_unused;

  assign level       = adc_data;
  assign hold_unused = (HOLD_SAMPLES > 0);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      to_cnt   <= '0;
      reg_load <= 1'b0;
      reg_data <= {DW{1'b1}};
      error    <= 1'b0;
    end else begin
      reg_load <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tick) state <= S_START;
        end
        S_START: begin
          to_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          // A done arriving on the expiry cycle still counts as a good conversion.
          if (adc_done) begin
            reg_load <= 1'b1;
            reg_data <= level;
            state    <= S_UPDATE;
          end else if (to_cnt == OW'(TIMEOUT - 1)) begin
            error    <= 1'b1;
            reg_load <= 1'b1;
            reg_data <= ERR_CODE;
            state    <= S_ERROR;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_UPDATE: begin
          state <= S_IDLE;
        end
        S_ERROR: begin
          if (error_clr) begin
            error <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vu_sample_ctrl.sv
// Scoreboard bench for vu_sample_ctrl: directed conversions push expected register loads,
// a monitor pops and compares them whenever reg_load is seen.
module tb_vu_sample_ctrl;

`ifdef VU_PEAK_HOLD_EN
  localparam bit PH = 1'b1;
`else
  localparam bit PH = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       adc_done = 1'b0;
  logic [7:0] adc_data = 8'h00;
  logic       error_clr = 1'b0;
  logic       adc_start, reg_enable, reg_load, error, busy;
  logic [7:0] reg_data;

  int n_cmp = 0;
  int n_fail = 0;
  int n_start = 0;
  int n_load = 0;
  logic [7:0] exp_q[$];

  vu_sample_ctrl #(
    .DW(8), .SAMPLE_DIV(8), .TIMEOUT(4), .HOLD_SAMPLES(2), .ERR_CODE(8'hFF)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .adc_done(adc_done),
    .adc_data(adc_data), .error_clr(error_clr), .adc_start(adc_start),
    .reg_enable(reg_enable), .reg_load(reg_load), .reg_data(reg_data),
    .error(error), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic       prev_load;
    logic [7:0] e;
    prev_load = 1'b0;
    forever begin
      @(negedge clock);
      if (adc_start) n_start++;
      if (reg_load) begin
        n_load++;
        check("load_gap", int'(prev_load), 0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_load: reg_data=%0h with no load expected", reg_data);
        end else begin
          e = exp_q.pop_front();
          check("reg_data", int'(reg_data), int'(e));
        end
      end
      prev_load = reg_load;
    end
  endtask

  task automatic wait_start(output int cycles);
    cycles = 0;
    do begin
      @(negedge clock);
      cycles++;
    end while (!adc_start && cycles < 40);
    if (!adc_start) begin
      n_cmp++;
      n_fail++;
      $display("FAIL start_timeout: adc_start absent after %0d cycles", cycles);
    end
  endtask

  // Called at the negedge of the START cycle; done is driven in WAIT cycle k (1..4).
  task automatic respond(input int k, input logic [7:0] d, input logic [7:0] e);
    repeat (k) @(posedge clock);
    #1;
    adc_done = 1'b1;
    adc_data = d;
    exp_q.push_back(e);
    @(posedge clock);
    #1 adc_done = 1'b0;
    @(negedge clock);
    check("busy_update", int'(busy), 1);
    @(negedge clock);
    check("busy_idle", int'(busy), 0);
  endtask

  task automatic conv(input int k, input logic [7:0] d, input logic [7:0] e);
    int c;
    wait_start(c);
    respond(k, d, e);
  endtask

  initial begin
    int c;
    int s;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clock);
    check("rst_reg_data", int'(reg_data), 8'hFF);
    check("rst_error", int'(error), 0);
    check("rst_reg_load", int'(reg_load), 0);
    check("rst_adc_start", int'(adc_start), 0);
    check("rst_busy", int'(busy), 0);

    reset  = 1'b0;
    enable = 1'b1;
    wait_start(c);
    check("start_latency", c, 8);
    check("reg_enable", int'(reg_enable), 1);
    respond(2, 8'h40, 8'h40);

    conv(1, 8'h80, 8'h80);
    conv(3, 8'h20, PH ? 8'h80 : 8'h20);
    conv(2, 8'h10, 8'h10);
    conv(1, 8'h05, PH ? 8'h10 : 8'h05);

    // Timeout: no done for four WAIT cycles.
    wait_start(c);
    exp_q.push_back(8'hFF);
    repeat (4) @(posedge clock);
    @(negedge clock);
    check("error_before_expiry", int'(error), 0);
    @(posedge clock);
    @(negedge clock);
    check("error_set", int'(error), 1);
    check("busy_in_error", int'(busy), 0);
    s = n_start;
    repeat (24) @(negedge clock);
    check("no_start_in_error", n_start - s, 0);
    check("error_sticky", int'(error), 1);
    error_clr = 1'b1;
    @(posedge clock);
    #1 error_clr = 1'b0;
    @(negedge clock);
    check("error_cleared", int'(error), 0);

    conv(4, 8'h33, 8'h33);
    check("error_after_late_done", int'(error), 0);

    // Synchronous reset in WAIT, then a stray done.
    wait_start(c);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("wait_rst_busy", int'(busy), 0);
    check("wait_rst_reg_data", int'(reg_data), 8'hFF);
    s = n_load;
    adc_done = 1'b1;
    adc_data = 8'h77;
    @(posedge clock);
    #1 adc_done = 1'b0;
    repeat (3) @(negedge clock);
    check("stray_done_ignored", n_load - s, 0);

    conv(2, 8'h80, 8'h80);
    conv(3, 8'h20, PH ? 8'h80 : 8'h20);

    repeat (4) @(negedge clock);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
